tdm_demux_1to2: RTL and testbench
=================================

TDM_DEMUX_1TO2 -- requirements
Module: tdm_demux_1to2

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have port din  input  1  interleaved serial data bit.
REQ-005 The block SHALL have port din_valid  input  1  din/sync qualify strobe (one beat per high cycle).
REQ-006 The block SHALL have port sync  input  1  frame marker; the qualified beat carrying it is slot 0.
REQ-007 The block SHALL have port out0  output  8  channel-0 word, MSB first on the line.
REQ-008 The block SHALL have port out1  output  8  channel-1 word, MSB first on the line.
REQ-009 The block SHALL have port out_valid  output  1  out0/out1 hold a complete frame.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts out0/out1 when high with out_valid.
REQ-011 The block SHALL have port overrun  output  1  one-cycle pulse, completed frame dropped.
REQ-012 The block SHALL have port sync_err  output  1  one-cycle pulse, sync seen at a slot other than 0.

Function
REQ-013 A frame SHALL be 16 qualified beats; slot k has sel = k[0]; even slots go to channel 0, odd slots to channel 1.
REQ-014 Channel words SHALL shift in MSB first: slot 0 is out0[7], slot 1 is out1[7], and so on to slot 14 as out0[0] and slot 15 as out1[0].
REQ-015 The FSM SHALL have two states: HUNT and RECV.
REQ-016 In HUNT, qualified beats without sync SHALL be discarded; a qualified beat with sync SHALL be stored as slot 0 and move the FSM to RECV with the slot counter at 1.
REQ-017 sync without din_valid SHALL be ignored in all states.
REQ-018 In RECV, each qualified beat SHALL be stored and SHALL advance the 4-bit slot counter, which wraps from 15 to 0 and stays in RECV; subsequent frames need no sync.
REQ-019 In RECV, sync on a qualified beat at slot 0 SHALL be accepted silently.
REQ-020 In RECV, sync on a qualified beat at slot 1..15 SHALL discard the partial frame, store the beat as slot 0, set the counter to 1 and pulse sync_err for one cycle.
REQ-021 The shift registers SHALL be separate from the output registers so that reception continues while out_valid is high.
REQ-022 On acceptance of slot 15, the frame SHALL load into out0/out1 and out_valid SHALL rise on the next cycle (latency 1 cycle from the slot-15 beat), provided out_valid is low or out_ready is high in that cycle.
REQ-023 out0/out1 SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL clear the cycle after out_valid&out_ready unless a new frame loads in that same cycle, in which case out_valid SHALL stay 1 with the new data.
REQ-025 A frame completing while out_valid=1 and out_ready=0 SHALL be dropped, SHALL keep the old data, and SHALL pulse overrun for one cycle.

Reset
REQ-026 rst SHALL asynchronously force state HUNT, slot counter 0, shift registers 0, out0=out1=0x00 and out_valid=overrun=sync_err=0.
REQ-027 rst mid-frame SHALL discard the partial frame; reception SHALL resume only at the next sync after rst deasserts.

Configuration
REQ-028 Macro DEMUX_NETS_EN SHALL, when defined, add output nets[6:0]: din, sel, ~sel, din&~sel, din&sel, din_valid, (state==RECV), indices 0..6, combinational from current state and inputs.
REQ-029 Without DEMUX_NETS_EN, port nets SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, sync on the first beat, then 16 beats encoding out0=0xA5 and out1=0x3C with out_ready=1 -> out_valid pulses 1 cycle after slot 15 with 0xA5/0x3C.
REQ-031 Two back-to-back frames (0x11/0x22, then 0x33/0x44), the second without sync, out_ready=0 until both complete -> 0x11/0x22 held and overrun pulses once at the second frame's slot 15.
REQ-032 Frame 0xFF/0x00 with din_valid gaps of 0-3 idle cycles between beats -> same words delivered; idle cycles do not advance the slot counter.
REQ-033 sync reasserted at slot 7, then a clean frame 0x5A/0xC3 -> sync_err pulses once and output is 0x5A/0xC3, with no partial data.
REQ-034 rst asserted at slot 9, beats without sync, then sync plus frame 0x81/0x7E -> all outputs 0 during rst, pre-sync beats ignored, then 0x81/0x7E delivered.
REQ-035 With DEMUX_NETS_EN, din=1 at slot 3 in RECV -> nets = 7'b1110011 (bit6..bit0), i.e. nets[4]=1 and nets[3]=0.

Source files
------------

// File: rtl/tdm_demux_1to2_if.sv
// Bus bundle for tdm_demux_1to2: serial TDM input side and the framed word output side.
// Handshakes: a beat transfers on every cycle din_valid=1 (no backpressure on the line);
// a frame transfers on every cycle out_valid=1 and out_ready=1, and the data holds until then.
interface tdm_demux_1to2_if;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic [7:0] out0;
  logic [7:0] out1;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       sync_err;
  logic       state_dbg;

  modport master (
    output din, din_valid, sync, out_ready,
    input  out0, out1, out_valid, overrun, sync_err, state_dbg
  );

  modport slave (
    input  din, din_valid, sync, out_ready,
    output out0, out1, out_valid, overrun, sync_err, state_dbg
  );
endinterface

// File: rtl/tdm_demux_1to2.sv
// 1-to-2 TDM demultiplexer: 16-slot frames, even slots to out0, odd slots to out1, MSB first.
// Optional macro DEMUX_NETS_EN adds the combinational observation port nets[6:0].
module tdm_demux_1to2 (
  input  logic                    clk,
  input  logic                    rst,
  tdm_demux_1to2_if.slave         bus
`ifdef DEMUX_NETS_EN
  ,
  output logic [6:0]              nets
`endif
);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [7:0] sh0_q, sh0_d;
  logic [7:0] sh1_q, sh1_d;
  logic [7:0] out0_q, out0_d;
  logic [7:0] out1_q, out1_d;
  logic       out_valid_q, out_valid_d;
  logic       overrun_q, overrun_d;
  logic       sync_err_q, sync_err_d;

  logic       frame_done;
  logic       out_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      slot_q      <= 4'd0;
      sh0_q       <= 8'h00;
      sh1_q       <= 8'h00;
      out0_q      <= 8'h00;
      out1_q      <= 8'h00;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Reception: FSM, slot counter and shift registers.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    sync_err_d = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      HUNT: begin
        if (bus.din_valid && bus.sync) begin
          sh0_d   = {7'b0, bus.din};
          sh1_d   = 8'h00;
          slot_d  = 4'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (bus.din_valid) begin
          if (bus.sync && (slot_q != 4'd0)) begin
            // Misplaced sync restarts the frame on this beat.
            sh0_d      = {7'b0, bus.din};
            sh1_d      = 8'h00;
            slot_d     = 4'd1;
            sync_err_d = 1'b1;
          end else begin
            if (slot_q[0] == 1'b0) begin
              sh0_d = {sh0_q[6:0], bus.din};
            end else begin
              sh1_d = {sh1_q[6:0], bus.din};
            end
            slot_d     = slot_q + 4'd1;
            frame_done = (slot_q == 4'd15);
          end
        end
      end
      default: begin
        state_d = HUNT;
        slot_d  = 4'd0;
      end
    endcase
  end

  // Output stage: holds the last complete frame independent of reception.
  always_comb begin
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    out_free    = !out_valid_q || bus.out_ready;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (frame_done) begin
      if (out_free) begin
        out0_d      = sh0_d;
        out1_d      = sh1_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign bus.out0      = out0_q;
  assign bus.out1      = out1_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.state_dbg = (state_q == RECV);

`ifdef DEMUX_NETS_EN
  logic sel;
  assign sel  = slot_q[0];
  assign nets = {(state_q == RECV), bus.din_valid, bus.din & sel, bus.din & ~sel,
                 ~sel, sel, bus.din};
`endif

endmodule

// File: tb/tb_tdm_demux_1to2.sv
// Directed + randomized bench for tdm_demux_1to2 against a frame-level reference model.
module tb_tdm_demux_1to2;

  logic clk;
  logic rst;
  tdm_demux_1to2_if bus ();
`ifdef DEMUX_NETS_EN
  logic [6:0] nets;
`endif

  tdm_demux_1to2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DEMUX_NETS_EN
    ,
    .nets(nets)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ovr_seen = 0;
  int serr_seen = 0;

  // Reference model: bits of the frame in progress, plus the presented output frame.
  logic       synced;
  logic       bits[$];
  logic [7:0] mo0, mo1;
  logic       mv, m_ovr, m_serr;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    synced = 1'b0;
    bits.delete();
    mo0 = 8'h00; mo1 = 8'h00;
    mv = 1'b0; m_ovr = 1'b0; m_serr = 1'b0;
  endtask

  // Applies one clock edge of behaviour using the inputs held across that edge.
  task automatic model_step();
    logic       prev_v, done;
    logic [7:0] w0, w1;
    prev_v = mv;
    m_ovr  = 1'b0;
    m_serr = 1'b0;
    done   = 1'b0;
    w0 = 8'h00; w1 = 8'h00;
    if (bus.din_valid) begin
      if (bus.sync) begin
        if (synced && bits.size() != 0) m_serr = 1'b1;
        bits.delete();
        bits.push_back(bus.din);
        synced = 1'b1;
      end else if (synced) begin
        bits.push_back(bus.din);
      end
      if (bits.size() == 16) begin
        for (int i = 0; i < 8; i++) begin
          w0[7-i] = bits[2*i];
          w1[7-i] = bits[2*i+1];
        end
        bits.delete();
        done = 1'b1;
      end
    end
    if (prev_v && bus.out_ready) mv = 1'b0;
    if (done) begin
      if (!prev_v || bus.out_ready) begin
        mo0 = w0; mo1 = w1; mv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("out0", bus.out0, mo0);
    check("out1", bus.out1, mo1);
    check("out_valid", {7'b0, bus.out_valid}, {7'b0, mv});
    check("overrun", {7'b0, bus.overrun}, {7'b0, m_ovr});
    check("sync_err", {7'b0, bus.sync_err}, {7'b0, m_serr});
    check("state", {7'b0, bus.state_dbg}, {7'b0, synced});
`ifdef DEMUX_NETS_EN
    begin
      logic s;
      s = synced ? bits.size() % 2 : 1'b0;
      check("nets", {1'b0, nets}, {1'b0, synced, bus.din_valid, bus.din & s, bus.din & ~s,
                                   ~s, s, bus.din});
    end
`endif
    ovr_seen  += int'(bus.overrun);
    serr_seen += int'(bus.sync_err);
  endtask

  // Driver tasks
  task automatic cycle(input logic d, input logic v, input logic s);
    bus.din = d; bus.din_valid = v; bus.sync = s;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    // Idle cycles carry random din/sync to show unqualified sync is ignored.
    for (int i = 0; i < n; i++) cycle(1'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1, input logic with_sync,
                            input int nslots, input int maxgap);
    logic b;
    for (int k = 0; k < nslots; k++) begin
      b = (k % 2 == 0) ? w0[7 - k/2] : w1[7 - k/2];
      cycle(b, 1'b1, with_sync && (k == 0));
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reset();
    bus.din_valid = 1'b0; bus.sync = 1'b0; bus.din = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.sync = 1'b0; bus.out_ready = 1'b1;
    model_reset();
    #2;
    do_reset();
    idle(2);

    // Basic frame with ready held high
    bus.out_ready = 1'b1;
    send_frame(8'hA5, 8'h3C, 1'b1, 16, 0);
    check("t1_valid", {7'b0, bus.out_valid}, 8'h01);
    check("t1_out0", bus.out0, 8'hA5);
    check("t1_out1", bus.out1, 8'h3C);
    idle(2);
    check("t1_cleared", {7'b0, bus.out_valid}, 8'h00);

    // Back-to-back frames under backpressure: second is dropped
    bus.out_ready = 1'b0;
    ovr_seen = 0;
    send_frame(8'h11, 8'h22, 1'b1, 16, 0);
    send_frame(8'h33, 8'h44, 1'b0, 16, 0);
    check("t2_out0_held", bus.out0, 8'h11);
    check("t2_out1_held", bus.out1, 8'h22);
    check("t2_overrun_count", 8'(ovr_seen), 8'd1);
    bus.out_ready = 1'b1;
    idle(2);

    // Gapped beats
    send_frame(8'hFF, 8'h00, 1'b0, 16, 3);
    check("t3_out0", bus.out0, 8'hFF);
    check("t3_out1", bus.out1, 8'h00);
    idle(1);

    // Misplaced sync at slot 7 then a clean frame
    serr_seen = 0;
    send_frame(8'hE7, 8'h9B, 1'b0, 7, 0);
    send_frame(8'h5A, 8'hC3, 1'b1, 16, 0);
    check("t4_serr_count", 8'(serr_seen), 8'd1);
    check("t4_out0", bus.out0, 8'h5A);
    check("t4_out1", bus.out1, 8'hC3);
    idle(2);

    // Reset mid-frame, unsynced beats ignored, then a synced frame
    send_frame(8'h6D, 8'hB2, 1'b0, 9, 0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'($urandom), 1'b1, 1'b0);
    check("t5_hunt", {7'b0, bus.state_dbg}, 8'h00);
    send_frame(8'h81, 8'h7E, 1'b1, 16, 0);
    check("t5_out0", bus.out0, 8'h81);
    check("t5_out1", bus.out1, 8'h7E);
    idle(2);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      cycle(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
